// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC sequencing controller.
// The state encoding is visible to the top FSM and anything that probes it.
package mac_seq_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int LEN_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/mac_seq_ctrl_watchdog.sv
// Stall watchdog: counts cycles with MAC work outstanding but no retirement,
// and raises a sticky error once the count reaches timeout_p.
module mac_seq_watchdog
    import mac_seq_pkg::*;
#(
    parameter int timeout_p = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic pending_i,
    input  logic retire_i,
    output logic err_o
);

    localparam int CNT_W = $clog2(timeout_p + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (clear_i) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (retire_i || !pending_i) begin
            cnt_reg <= '0;
        end else if (cnt_reg != CNT_W'(timeout_p)) begin
            // Counter saturates at the limit; the flag stays set until the next job.
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(timeout_p - 1)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err_o = err_reg;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer for a single MAC PE: flush, stream L operand
// pairs, retire L MAC outputs, then hand back the final accumulator.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int width_p     = WIDTH_DEF,
    parameter int len_width_p = LEN_WIDTH_DEF,
    parameter int timeout_p   = TIMEOUT_DEF
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [len_width_p-1:0] cmd_len_i,
    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    input  logic [width_p-1:0]     op_a_i,
    input  logic [width_p-1:0]     op_b_i,
    output logic                   mac_en_o,
    output logic                   mac_flush_o,
    output logic                   mac_a_valid_o,
    input  logic                   mac_a_ready_i,
    output logic [width_p-1:0]     mac_a_o,
    output logic                   mac_b_valid_o,
    input  logic                   mac_b_ready_i,
    output logic [width_p-1:0]     mac_b_o,
    input  logic                   mac_a_valid_i,
    input  logic                   mac_b_valid_i,
    output logic                   mac_a_yumi_o,
    output logic                   mac_b_yumi_o,
    input  logic [width_p-1:0]     mac_accum_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [width_p-1:0]     res_o,
    output logic                   err_o
);

    // One extra bit so the largest job length never wraps the counters.
    localparam int CNT_W = len_width_p + 1;

    state_e             state_reg;
    logic [CNT_W-1:0]   len_reg;
    logic [CNT_W-1:0]   issued_reg;
    logic [CNT_W-1:0]   done_reg;
    logic [width_p-1:0] res_reg;
    logic               cmd_ready_reg;
    logic               mac_en_reg;
    logic               mac_flush_reg;
    logic               res_valid_reg;

    logic             in_feed;
    logic             in_flow;
    logic             fire;
    logic             retire;
    logic             cmd_accept;
    logic [CNT_W-1:0] issued_next;
    logic [CNT_W-1:0] done_next;

    assign in_feed     = (state_reg == FEED);
    assign in_flow     = in_feed || (state_reg == DRAIN);
    assign cmd_accept  = (state_reg == IDLE) && cmd_ready_reg && cmd_valid_i;
    // A and B issue on a single shared condition so they can never split.
    assign fire        = in_feed && op_valid_i && mac_a_ready_i && mac_b_ready_i
                         && (issued_reg < len_reg);
    assign retire      = in_flow && mac_a_valid_i && mac_b_valid_i && (done_reg < issued_reg);
    assign issued_next = issued_reg + CNT_W'(fire);
    assign done_next   = done_reg + CNT_W'(retire);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            issued_reg    <= '0;
            done_reg      <= '0;
            res_reg       <= '0;
            cmd_ready_reg <= 1'b0;
            mac_en_reg    <= 1'b0;
            mac_flush_reg <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            issued_reg <= issued_next;
            done_reg   <= done_next;
            unique case (state_reg)
                IDLE: begin
                    if (cmd_accept) begin
                        len_reg       <= {1'b0, cmd_len_i};
                        issued_reg    <= '0;
                        done_reg      <= '0;
                        cmd_ready_reg <= 1'b0;
                        mac_en_reg    <= 1'b1;
                        mac_flush_reg <= 1'b1;
                        state_reg     <= CLEAR;
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                CLEAR: begin
                    mac_flush_reg <= 1'b0;
                    if (len_reg == '0) begin
                        res_reg       <= '0;
                        mac_en_reg    <= 1'b0;
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        state_reg <= FEED;
                    end
                end
                FEED: begin
                    if (issued_next == len_reg) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (retire && (done_next == len_reg)) begin
                        res_reg       <= mac_accum_i;
                        mac_en_reg    <= 1'b0;
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        res_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    mac_seq_watchdog #(
        .timeout_p(timeout_p)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (cmd_accept),
        .pending_i(done_reg < issued_reg),
        .retire_i (retire),
        .err_o    (err_o)
    );

    assign cmd_ready_o   = cmd_ready_reg;
    assign op_ready_o    = fire;
    assign mac_en_o      = mac_en_reg;
    assign mac_flush_o   = mac_flush_reg;
    assign mac_a_valid_o = fire;
    assign mac_b_valid_o = fire;
    assign mac_a_o       = in_feed ? op_a_i : '0;
    assign mac_b_o       = in_feed ? op_b_i : '0;
    assign mac_a_yumi_o  = retire;
    assign mac_b_yumi_o  = retire;
    assign res_valid_o   = res_valid_reg;
    assign res_o         = res_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: vector table of dot-product jobs against a
// behavioural one-cycle MAC, plus watchdog and mid-job reset sequences.
module tb_mac_seq_ctrl;

    localparam int W  = 32;
    localparam int LW = 8;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [LW-1:0] cmd_len_i = '0;
    logic          op_valid_i = 1'b0;
    logic          op_ready_o;
    logic [W-1:0]  op_a_i = '0;
    logic [W-1:0]  op_b_i = '0;
    logic          mac_en_o;
    logic          mac_flush_o;
    logic          mac_a_valid_o;
    logic          mac_a_ready_i = 1'b1;
    logic [W-1:0]  mac_a_o;
    logic          mac_b_valid_o;
    logic          mac_b_ready_i = 1'b1;
    logic [W-1:0]  mac_b_o;
    logic          mac_a_valid_i;
    logic          mac_b_valid_i;
    logic          mac_a_yumi_o;
    logic          mac_b_yumi_o;
    logic [W-1:0]  mac_accum_i;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [W-1:0]  res_o;
    logic          err_o;

    mac_seq_ctrl dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_len_i    (cmd_len_i),
        .op_valid_i   (op_valid_i),
        .op_ready_o   (op_ready_o),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .mac_en_o     (mac_en_o),
        .mac_flush_o  (mac_flush_o),
        .mac_a_valid_o(mac_a_valid_o),
        .mac_a_ready_i(mac_a_ready_i),
        .mac_a_o      (mac_a_o),
        .mac_b_valid_o(mac_b_valid_o),
        .mac_b_ready_i(mac_b_ready_i),
        .mac_b_o      (mac_b_o),
        .mac_a_valid_i(mac_a_valid_i),
        .mac_b_valid_i(mac_b_valid_i),
        .mac_a_yumi_o (mac_a_yumi_o),
        .mac_b_yumi_o (mac_b_yumi_o),
        .mac_accum_i  (mac_accum_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_o        (res_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural MAC: product lands one cycle after issue, output held until yumi.
    logic [W-1:0] acc_m = '0;
    int           pend_m = 0;
    bit           mute = 1'b0;
    logic         issue_w;
    logic         yumi_w;

    assign issue_w       = mac_a_valid_o && mac_a_ready_i && mac_b_valid_o && mac_b_ready_i;
    assign yumi_w        = mac_a_yumi_o && mac_b_yumi_o;
    assign mac_a_valid_i = !mute && (pend_m > 0);
    assign mac_b_valid_i = !mute && (pend_m > 0);
    assign mac_accum_i   = acc_m;

    always @(posedge clk_i) begin
        if (mac_flush_o) begin
            acc_m  <= '0;
            pend_m <= 0;
        end else begin
            if (issue_w) acc_m <= acc_m + mac_a_o * mac_b_o;
            pend_m <= pend_m + (issue_w ? 1 : 0) - (yumi_w ? 1 : 0);
        end
    end

    int flush_cnt = 0, issue_cnt = 0, valid_cnt = 0, yumi_cnt = 0, split_cnt = 0, order_bad = 0;

    always @(posedge clk_i) begin
        if (reset_i) begin
            if (issue_w) begin
                if (flush_cnt == 0) order_bad++;
                issue_cnt++;
            end
            if (mac_flush_o) flush_cnt++;
            if (mac_a_valid_o || mac_b_valid_o) valid_cnt++;
            if (yumi_w) yumi_cnt++;
            if ((mac_a_valid_o != mac_b_valid_o) || (mac_a_yumi_o != mac_b_yumi_o)) split_cnt++;
        end
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        flush_cnt = 0; issue_cnt = 0; valid_cnt = 0;
        yumi_cnt = 0; split_cnt = 0; order_bad = 0;
    endtask

    typedef struct {
        int              len;
        logic [3:0][W-1:0] a;
        logic [3:0][W-1:0] b;
        int              gap;
        bit              bstall;
        logic [W-1:0]    exp_res;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input int len, input logic [W-1:0] a0, b0, a1, b1, a2, b2, a3, b3,
                                input int gap, input bit bstall, input logic [W-1:0] exp_res);
        vec_t v;
        v.len = len;
        v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
        v.a[2] = a2; v.b[2] = b2; v.a[3] = a3; v.b[3] = b3;
        v.gap = gap; v.bstall = bstall; v.exp_res = exp_res;
        return v;
    endfunction

    task automatic send_cmd(input int len, input string nm);
        int n = 0;
        cmd_valid_i = 1'b1;
        cmd_len_i   = LW'(len);
        #1;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk_i); #1; n++;
        end
        if (n >= 50) chk({nm, "_cmd_ready_timeout"}, 0, 1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic feed_op(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        int n = 0;
        op_valid_i = 1'b1;
        op_a_i = a;
        op_b_i = b;
        #1;
        while (!op_ready_o && n < 100) begin
            @(negedge clk_i); #1; n++;
        end
        if (n >= 100) chk({nm, "_op_ready_timeout"}, 0, 1);
        @(negedge clk_i);
        op_valid_i = 1'b0;
    endtask

    task automatic finish_res(input logic [W-1:0] exp_res, input string nm);
        int n = 0;
        #1;
        while (!res_valid_o && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        chk({nm, "_res_valid"}, res_valid_o, 1);
        chk({nm, "_res"}, res_o, exp_res);
        repeat (3) @(negedge clk_i);
        chk({nm, "_res_held"}, {res_valid_o, res_o}, {1'b1, exp_res});
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        #1;
        chk({nm, "_res_dropped"}, res_valid_o, 0);
    endtask

    task automatic run_job(input int v);
        vec_t  t = vecs[v];
        string nm = $sformatf("v%0d", v);
        int    stall_bad = 0;
        clear_mon();
        send_cmd(t.len, nm);
        for (int k = 0; k < t.len; k++) begin
            repeat (t.gap) @(negedge clk_i);
            if (t.bstall && k == 1) begin
                mac_b_ready_i = 1'b0;
                op_valid_i = 1'b1;
                op_a_i = t.a[k];
                op_b_i = t.b[k];
                repeat (4) begin
                    #1;
                    if (op_ready_o || mac_a_valid_o || mac_b_valid_o) stall_bad++;
                    @(negedge clk_i);
                end
                mac_b_ready_i = 1'b1;
            end
            feed_op(t.a[k], t.b[k], nm);
        end
        finish_res(t.exp_res, nm);
        chk({nm, "_flush_cnt"}, flush_cnt, 1);
        chk({nm, "_flush_first"}, order_bad, 0);
        chk({nm, "_issues"}, issue_cnt, t.len);
        chk({nm, "_valid_pulses"}, valid_cnt, t.len);
        chk({nm, "_yumis"}, yumi_cnt, t.len);
        chk({nm, "_split"}, split_cnt, 0);
        chk({nm, "_err"}, err_o, 0);
        if (t.bstall) chk({nm, "_bstall_hold"}, stall_bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        vecs[0] = mk(1, 322, 465, 0, 0, 0, 0, 0, 0, 0, 0, 32'd149730);
        vecs[1] = mk(2, 322, 465, 1750, 33824, 0, 0, 0, 0, 0, 0, 32'd59341730);
        vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
        vecs[3] = mk(3, 3, 5, 7, 11, 100000, 70000, 0, 0, 2, 1, 32'd2705032796);
        vecs[4] = mk(4, 1, 1, 2, 2, 3, 3, 4, 4, 1, 0, 32'd30);
        vecs[5] = mk(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1);

        // Reset state and release behaviour
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_outputs", {mac_en_o, mac_flush_o, res_valid_o, err_o, op_ready_o}, 0);
        reset_i = 1'b1;
        #1;
        chk("release_cmd_ready_low", cmd_ready_o, 0);
        @(negedge clk_i);
        chk("release_cmd_ready_high", cmd_ready_o, 1);

        for (int v = 0; v < 6; v++) run_job(v);

        // Watchdog: MAC withholds its output after one issue
        clear_mon();
        mute = 1'b1;
        send_cmd(1, "wd");
        feed_op(5, 6, "wd");
        n = 0;
        #1;
        while (!err_o && n < 40) begin
            @(negedge clk_i); #1; n++;
        end
        chk("wd_latency", n, 16);
        repeat (3) @(negedge clk_i);
        chk("wd_sticky", err_o, 1);
        chk("wd_no_abort", {mac_en_o, res_valid_o}, 2'b10);
        mute = 1'b0;
        finish_res(32'd30, "wd");
        chk("wd_err_after_done", err_o, 1);
        send_cmd(1, "wd2");
        #1;
        chk("wd_err_cleared", err_o, 0);
        feed_op(2, 3, "wd2");
        finish_res(32'd6, "wd2");

        // Asynchronous reset in the middle of FEED
        clear_mon();
        send_cmd(2, "rst");
        feed_op(4, 5, "rst");
        op_valid_i = 1'b1;
        op_a_i = 9;
        op_b_i = 9;
        #1;
        chk("rst_pre_valid", mac_a_valid_o, 1);
        reset_i = 1'b0;
        #1;
        chk("rst_async_valid", {mac_a_valid_o, mac_b_valid_o, op_ready_o}, 0);
        chk("rst_async_data", {mac_a_o, mac_b_o}, 0);
        chk("rst_async_ctrl", {mac_en_o, cmd_ready_o, res_valid_o}, 0);
        op_valid_i = 1'b0;
        @(negedge clk_i);
        clear_mon();
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_no_flush", flush_cnt, 0);
        run_job(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
